// File: rtl/io_cycle_responder.sv
// ---------------------------------------------------------------------------
// io_cycle_responder
//
// Purpose:
//   Answers CPU I/O cycles. A fresh rising level on ioread or iowrite starts
//   a cycle: the address and write data are latched, a programmable number of
//   wait states is inserted (io_ready low), and on completion a one-clock
//   read/write strobe is issued together with the registered read data.
//   Ports 30h-33h (IDE 8255) get their own wait-state count and hold
//   ide_rd/ide_wr for the whole cycle; port 35h drives the USB FIFO pop/push.
//
// Parameters:
//   WS_IDE      wait-state clocks for ports 30h-33h
//   WS_DEFAULT  wait-state clocks for every other port
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous active-high reset
//   address      CPU I/O port address A7-A0
//   ioread       high during an I/O read cycle (sINP)
//   iowrite      high during an I/O write cycle (sOUT)
//   cpu_dout     CPU write data
//   iobyte_in    read source for port 36h
//   usb_status   read source for ports 00h/34h
//   usb_rxd      read source for ports 01h/35h
//   fbar_in      read source for port 06h
//   ide_rdata    read source for ports 30h-33h
//   cpu_din      registered read data (FFh outside a completed read)
//   io_ready     low while wait states are being inserted
//   port_q       address latched at cycle start
//   wdata_q      write data latched at cycle start
//   rd_strobe    one-clock pulse on read completion
//   wr_strobe    one-clock pulse on write completion
//   usb_rx_pop   one-clock pulse on completed read of port 35h
//   usb_tx_push  one-clock pulse on completed write of port 35h
//   ide_rd       high through WAIT and DONE of an IDE read
//   ide_wr       high through WAIT and DONE of an IDE write
// ---------------------------------------------------------------------------
module io_cycle_responder #(
  parameter int WS_IDE     = 3,
  parameter int WS_DEFAULT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       ioread,
  input  logic       iowrite,
  input  logic [7:0] cpu_dout,
  input  logic [7:0] iobyte_in,
  input  logic [7:0] usb_status,
  input  logic [7:0] usb_rxd,
  input  logic [7:0] fbar_in,
  input  logic [7:0] ide_rdata,
  output logic [7:0] cpu_din,
  output logic       io_ready,
  output logic [7:0] port_q,
  output logic [7:0] wdata_q,
  output logic       rd_strobe,
  output logic       wr_strobe,
  output logic       usb_rx_pop,
  output logic       usb_tx_push,
  output logic       ide_rd,
  output logic       ide_wr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] WS_IDE_C     = 8'(WS_IDE);
  localparam logic [7:0] WS_DEFAULT_C = 8'(WS_DEFAULT);
  localparam logic [7:0] USB_DATA_PORT = 8'h35;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       cycle_write;
  logic       io_prev;

  // Read-data source selection by port number; unmapped ports read FFh.
  function automatic logic [7:0] read_mux(
    input logic [7:0] port,
    input logic [7:0] src_iobyte,
    input logic [7:0] src_status,
    input logic [7:0] src_rxd,
    input logic [7:0] src_fbar,
    input logic [7:0] src_ide
  );
    logic [7:0] result;
    case (port)
      8'h00, 8'h34:               result = src_status;
      8'h01, 8'h35:               result = src_rxd;
      8'h06:                      result = src_fbar;
      8'h36:                      result = src_iobyte;
      8'h30, 8'h31, 8'h32, 8'h33: result = src_ide;
      default:                    result = 8'hFF;
    endcase
    return result;
  endfunction

  logic       io_active;
  logic       cycle_start;
  logic       start_illegal;
  logic       start_ide;
  logic [7:0] start_count;
  logic       wait_abort;

  // Cycle start needs a fresh low-to-high level; io_prev is forced high in
  // reset so a level held through reset is not mistaken for an edge.
  always_comb begin
    io_active     = ioread | iowrite;
    cycle_start   = (state == IDLE) && io_active && !io_prev;
    start_illegal = ioread & iowrite;
    start_ide     = (address[7:2] == 6'b001100);
    start_count   = start_ide ? WS_IDE_C : WS_DEFAULT_C;
    wait_abort    = cycle_write ? !iowrite : !ioread;
  end

  logic       done_entry;
  logic       done_write;
  logic [7:0] done_port;
  logic [7:0] done_rdata;

  // Completion happens either straight from IDLE (zero wait states) or at
  // the end of WAIT. In the IDLE case port_q is not yet loaded, so the live
  // address is used; it is the same value port_q captures on that edge.
  always_comb begin
    done_entry = 1'b0;
    done_write = 1'b0;
    done_port  = port_q;
    if (cycle_start && !start_illegal && (start_count == 8'd0)) begin
      done_entry = 1'b1;
      done_write = iowrite;
      done_port  = address;
    end else if ((state == WAIT) && !wait_abort && (wait_cnt <= 8'd1)) begin
      done_entry = 1'b1;
      done_write = cycle_write;
      done_port  = port_q;
    end
    done_rdata = read_mux(done_port, iobyte_in, usb_status, usb_rxd,
                          fbar_in, ide_rdata);
  end

  // Main cycle FSM with all outputs registered. Pulses default low every
  // clock and are raised only on the DONE entry edge, so a held DONE never
  // produces a second strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      cycle_write <= 1'b0;
      io_prev     <= 1'b1;
      cpu_din     <= 8'hFF;
      io_ready    <= 1'b1;
      port_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rd_strobe   <= 1'b0;
      wr_strobe   <= 1'b0;
      usb_rx_pop  <= 1'b0;
      usb_tx_push <= 1'b0;
      ide_rd      <= 1'b0;
      ide_wr      <= 1'b0;
    end else begin
      io_prev     <= io_active;
      rd_strobe   <= 1'b0;
      wr_strobe   <= 1'b0;
      usb_rx_pop  <= 1'b0;
      usb_tx_push <= 1'b0;

      case (state)
        IDLE: begin
          if (cycle_start) begin
            port_q      <= address;
            wdata_q     <= cpu_dout;
            cycle_write <= iowrite & !ioread;
            if (start_illegal) begin
              // Both status lines high: park in DONE with no side effects.
              state <= DONE;
            end else begin
              ide_rd <= start_ide & ioread;
              ide_wr <= start_ide & iowrite;
              if (start_count != 8'd0) begin
                wait_cnt <= start_count;
                io_ready <= 1'b0;
                state    <= WAIT;
              end else begin
                state <= DONE;
              end
            end
          end
        end

        WAIT: begin
          if (wait_abort) begin
            // The CPU dropped its status line early: abandon silently.
            state    <= IDLE;
            wait_cnt <= 8'd0;
            io_ready <= 1'b1;
            ide_rd   <= 1'b0;
            ide_wr   <= 1'b0;
          end else if (wait_cnt <= 8'd1) begin
            wait_cnt <= 8'd0;
            io_ready <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end

        DONE: begin
          if (!io_active) begin
            state   <= IDLE;
            cpu_din <= 8'hFF;
            ide_rd  <= 1'b0;
            ide_wr  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          io_ready <= 1'b1;
        end
      endcase

      if (done_entry) begin
        if (done_write) begin
          wr_strobe   <= 1'b1;
          usb_tx_push <= (done_port == USB_DATA_PORT);
        end else begin
          rd_strobe   <= 1'b1;
          usb_rx_pop  <= (done_port == USB_DATA_PORT);
          cpu_din     <= done_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_cycle_responder.sv
// ---------------------------------------------------------------------------
// tb_io_cycle_responder
//
// Directed bench for io_cycle_responder with default parameters
// (WS_IDE = 3, WS_DEFAULT = 0). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_io_cycle_responder;

  logic       clock;
  logic       reset;
  logic [7:0] address;
  logic       ioread;
  logic       iowrite;
  logic [7:0] cpu_dout;
  logic [7:0] iobyte_in;
  logic [7:0] usb_status;
  logic [7:0] usb_rxd;
  logic [7:0] fbar_in;
  logic [7:0] ide_rdata;
  logic [7:0] cpu_din;
  logic       io_ready;
  logic [7:0] port_q;
  logic [7:0] wdata_q;
  logic       rd_strobe;
  logic       wr_strobe;
  logic       usb_rx_pop;
  logic       usb_tx_push;
  logic       ide_rd;
  logic       ide_wr;

  int checkCount;
  int errorCount;

  io_cycle_responder dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .ioread      (ioread),
    .iowrite     (iowrite),
    .cpu_dout    (cpu_dout),
    .iobyte_in   (iobyte_in),
    .usb_status  (usb_status),
    .usb_rxd     (usb_rxd),
    .fbar_in     (fbar_in),
    .ide_rdata   (ide_rdata),
    .cpu_din     (cpu_din),
    .io_ready    (io_ready),
    .port_q      (port_q),
    .wdata_q     (wdata_q),
    .rd_strobe   (rd_strobe),
    .wr_strobe   (wr_strobe),
    .usb_rx_pop  (usb_rx_pop),
    .usb_tx_push (usb_tx_push),
    .ide_rd      (ide_rd),
    .ide_wr      (ide_wr)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one clock and settle 1 ns past the edge before sampling/driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [7:0] dout);
    ioread   = rd;
    iowrite  = wr;
    address  = addr;
    cpu_dout = dout;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Zero-wait read table: port and the value it must return.
  logic [7:0] tblPort [6];
  logic [7:0] tblData [6];

  initial begin
    int lowCount;
    int rdCount;
    int wrCount;
    int popCount;
    int pushCount;
    int badCount;

    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    iobyte_in  = 8'hA5;
    usb_status = 8'h5A;
    usb_rxd    = 8'h3C;
    fbar_in    = 8'h96;
    ide_rdata  = 8'hD2;
    // ioread held high through reset must not start a cycle afterwards.
    applyStimulus(1'b1, 1'b0, 8'h36, 8'h00);
    tick();
    tick();
    reset = 1'b0;

    lowCount = 0;
    rdCount  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!io_ready) lowCount++;
      if (rd_strobe) rdCount++;
    end
    checkOutput("held_level_no_strobe", rdCount, 0);
    checkOutput("held_level_ready", lowCount, 0);
    checkOutput("reset_port_q", port_q, 8'h00);
    checkOutput("reset_wdata_q", wdata_q, 8'h00);
    checkOutput("reset_cpu_din", cpu_din, 8'hFF);
    checkOutput("reset_io_ready", io_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Read port 36h with zero wait states.
    applyStimulus(1'b1, 1'b0, 8'h36, 8'h00);
    tick();
    checkOutput("rd36_strobe", rd_strobe, 1'b1);
    checkOutput("rd36_cpu_din", cpu_din, 8'hA5);
    checkOutput("rd36_io_ready", io_ready, 1'b1);
    checkOutput("rd36_port_q", port_q, 8'h36);
    tick();
    checkOutput("rd36_strobe_one_clock", rd_strobe, 1'b0);
    checkOutput("rd36_cpu_din_hold", cpu_din, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("rd36_idle_cpu_din", cpu_din, 8'hFF);
    tick();

    // Write 42h to IDE port 32h: three wait states.
    applyStimulus(1'b0, 1'b1, 8'h32, 8'h42);
    lowCount = 0;
    wrCount  = 0;
    badCount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) applyStimulus(1'b0, 1'b1, 8'h00, 8'h99);
      if (!io_ready) lowCount++;
      if (wr_strobe) begin
        wrCount++;
        if (i != 3) badCount++;
      end
      if (!ide_wr) badCount++;
    end
    checkOutput("wr32_wait_clocks", lowCount, 3);
    checkOutput("wr32_strobe_count", wrCount, 1);
    checkOutput("wr32_ide_wr_timing", badCount, 0);
    checkOutput("wr32_wdata_q", wdata_q, 8'h42);
    checkOutput("wr32_port_q", port_q, 8'h32);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("wr32_ide_wr_released", ide_wr, 1'b0);
    tick();

    // Read port 35h held for 10 clocks.
    applyStimulus(1'b1, 1'b0, 8'h35, 8'h00);
    rdCount  = 0;
    popCount = 0;
    badCount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_strobe) rdCount++;
      if (usb_rx_pop) popCount++;
      if (cpu_din !== 8'h3C) badCount++;
    end
    checkOutput("rd35_strobe_count", rdCount, 1);
    checkOutput("rd35_pop_count", popCount, 1);
    checkOutput("rd35_cpu_din_hold", badCount, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("rd35_idle_cpu_din", cpu_din, 8'hFF);
    tick();

    // Remaining zero-wait read sources, including an unmapped port.
    tblPort[0] = 8'h00; tblData[0] = 8'h5A;
    tblPort[1] = 8'h34; tblData[1] = 8'h5A;
    tblPort[2] = 8'h01; tblData[2] = 8'h3C;
    tblPort[3] = 8'h06; tblData[3] = 8'h96;
    tblPort[4] = 8'h7F; tblData[4] = 8'hFF;
    tblPort[5] = 8'h37; tblData[5] = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, tblPort[i], 8'h00);
      tick();
      checkOutput($sformatf("rd%02h_cpu_din", tblPort[i]), cpu_din, tblData[i]);
      checkOutput($sformatf("rd%02h_strobe", tblPort[i]), rd_strobe, 1'b1);
      checkOutput($sformatf("rd%02h_no_pop", tblPort[i]), usb_rx_pop, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      tick();
    end

    // Write to 35h pushes to the USB FIFO.
    applyStimulus(1'b0, 1'b1, 8'h35, 8'h77);
    tick();
    checkOutput("wr35_push", usb_tx_push, 1'b1);
    checkOutput("wr35_strobe", wr_strobe, 1'b1);
    checkOutput("wr35_no_rd_strobe", rd_strobe, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();

    // Illegal cycle: both lines high on port 35h.
    applyStimulus(1'b1, 1'b1, 8'h35, 8'h11);
    rdCount   = 0;
    wrCount   = 0;
    popCount  = 0;
    pushCount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rd_strobe) rdCount++;
      if (wr_strobe) wrCount++;
      if (usb_rx_pop) popCount++;
      if (usb_tx_push) pushCount++;
    end
    checkOutput("illegal_strobes", rdCount + wrCount, 0);
    checkOutput("illegal_pop_push", popCount + pushCount, 0);
    checkOutput("illegal_cpu_din", cpu_din, 8'hFF);
    checkOutput("illegal_port_q", port_q, 8'h35);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();

    // Reset in the second WAIT clock of an IDE read.
    applyStimulus(1'b1, 1'b0, 8'h31, 8'h00);
    tick();
    checkOutput("ide_rd_wait_ready", io_ready, 1'b0);
    checkOutput("ide_rd_asserted", ide_rd, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_reset_ready", io_ready, 1'b1);
    checkOutput("mid_reset_ide_rd", ide_rd, 1'b0);
    checkOutput("mid_reset_no_strobe", rd_strobe, 1'b0);
    lowCount = 0;
    rdCount  = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!io_ready) lowCount++;
      if (rd_strobe) rdCount++;
    end
    checkOutput("post_reset_no_cycle", lowCount + rdCount, 0);

    // Fresh edge after reset starts a cycle; dropping ioread in WAIT aborts.
    applyStimulus(1'b0, 1'b0, 8'h31, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h30, 8'h00);
    tick();
    checkOutput("fresh_edge_wait", io_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h30, 8'h00);
    rdCount = 0;
    tick();
    checkOutput("abort_ready", io_ready, 1'b1);
    checkOutput("abort_ide_rd", ide_rd, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (rd_strobe) rdCount++;
      tick();
    end
    checkOutput("abort_no_strobe", rdCount, 0);
    checkOutput("abort_cpu_din", cpu_din, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/io_cycle_responder.md
IO_CYCLE_RESPONDER -- requirements
Module: io_cycle_responder

Interface
REQ-001 Parameter WS_IDE, default 3: wait-state clocks inserted for IDE 8255 ports 30h-33h.
REQ-002 Parameter WS_DEFAULT, default 0: wait-state clocks inserted for all other ports.
REQ-003 clock  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 address  in  8  CPU I/O port address A7-A0.
REQ-006 ioread  in  1  sINP status, high during an I/O read cycle.
REQ-007 iowrite  in  1  sOUT status, high during an I/O write cycle.
REQ-008 cpu_dout  in  8  CPU write data.
REQ-009 iobyte_in, usb_status, usb_rxd, fbar_in, ide_rdata  in  8 each  read sources for ports 36h, 34h, 35h, 06h and 30h-33h.
REQ-010 cpu_din  out  8  registered read data returned to the CPU.
REQ-011 io_ready  out  1  low = insert wait state.
REQ-012 port_q  out  8  address latched at cycle start.
REQ-013 wdata_q  out  8  write data latched at cycle start.
REQ-014 rd_strobe, wr_strobe  out  1 each  one-clock completion pulses for any read or write cycle.
REQ-015 usb_rx_pop, usb_tx_push  out  1 each  one-clock pulses on completed read or write of port 35h.
REQ-016 ide_rd, ide_wr  out  1 each  held high throughout WAIT and DONE of an IDE read or write cycle.

Function
REQ-017 FSM states: IDLE, WAIT, DONE.
REQ-018 Cycle start: ioread OR iowrite is high while in IDLE and was low the previous clock; a level held high from reset does not start a cycle.
REQ-019 At cycle start: latch address into port_q, cpu_dout into wdata_q and the cycle kind (read or write); load the wait counter with WS_IDE if address[7:2]=6'b001100, else WS_DEFAULT.
REQ-020 IDLE -> WAIT when the loaded count is nonzero; IDLE -> DONE when it is zero.
REQ-021 WAIT: decrement the counter each clock; go to DONE on the clock the counter reaches 0, giving exactly N clocks in WAIT for N wait states.
REQ-022 io_ready is registered: 1 in IDLE and DONE, 0 in WAIT.
REQ-023 DONE entry: rd_strobe or wr_strobe pulses for exactly one clock.
REQ-024 DONE entry: usb_rx_pop or usb_tx_push pulses for exactly one clock when port_q = 35h.
REQ-025 DONE entry, read cycles: cpu_din captures the source selected by port_q:
- 00h or 34h -> usb_status
- 01h or 35h -> usb_rxd
- 06h -> fbar_in
- 36h -> iobyte_in
- 30h-33h -> ide_rdata
- any other port -> FFh
REQ-026 cpu_din holds its value throughout DONE and is FFh in IDLE and WAIT.
REQ-027 DONE -> IDLE only when ioread and iowrite are both low; no second strobe is issued while DONE is held.
REQ-028 ioread and iowrite both high at cycle start: illegal cycle; go directly to DONE with no strobes, no pops or pushes, no ide_rd or ide_wr, cpu_din = FFh.
REQ-029 ioread or iowrite dropping during WAIT aborts the cycle: return to IDLE next clock with no strobes.
REQ-030 address and cpu_dout changes after cycle start have no effect; only port_q and wdata_q are used.

Reset
REQ-031 reset wins over every other input on the same edge.
REQ-032 Reset values: state IDLE, counter 0, cpu_din FFh, io_ready 1, port_q 00h, wdata_q 00h, all strobe, pop, push and ide outputs 0.
REQ-033 reset asserted mid-cycle abandons the cycle with no strobe.
REQ-034 After reset release, a cycle starts only on a fresh low-to-high edge of ioread or iowrite.

Verification
REQ-035 Read port 36h, iobyte_in=A5h, WS_DEFAULT=0 -> next clock DONE, cpu_din=A5h, rd_strobe one clock, io_ready never low.
REQ-036 Write 42h to port 32h -> io_ready low exactly 3 clocks, ide_wr high from WAIT through DONE, then wr_strobe one clock, wdata_q=42h.
REQ-037 Read port 35h, ioread held 10 clocks -> exactly one usb_rx_pop and one rd_strobe, cpu_din=usb_rxd for the whole hold, then IDLE.
REQ-038 Read port 7Fh (unmapped) -> cpu_din=FFh, rd_strobe pulses, no pop.
REQ-039 ioread and iowrite asserted together on port 35h -> DONE with no strobes, no pop or push, cpu_din=FFh.
REQ-040 reset asserted in the second WAIT clock of an IDE read -> next clock IDLE, io_ready=1, no rd_strobe, ide_rd=0.
